// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction fields into 32-bit words and streams them into
// instruction memory through one registered write stage.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// LOAD  | accepting bundles until one with in_last is taken
module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              full,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {IDLE, LOAD} state_t;

   state_t            state;
   logic [ADDR_W:0]   wr_ptr;
   logic              hs;
   logic              legal;
   logic [5:0]        opc;
   logic [31:0]       word;

   always_comb begin
      legal = 1'b1;
      opc   = 6'b000000;
      word  = 32'h0;
      case (in_op)
         4'd1:    opc = 6'b001000;
         4'd2:    opc = 6'b110001;
         4'd3:    opc = 6'b101011;
         4'd4:    opc = 6'b000100;
         4'd5:    opc = 6'b001010;
         4'd7:    opc = 6'b001100;
         4'd8:    opc = 6'b001101;
         default: opc = 6'b000000;
      endcase
      case (in_op)
         4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
         4'd6:    word = {6'b000010, in_target};
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8:
                  word = {opc, in_rs, in_rt, in_imm};
         default: legal = 1'b0;
      endcase
   end

   assign in_ready = (state == LOAD) && (wr_ptr < DEPTH);
   assign hs       = in_valid && in_ready;
   assign count    = wr_ptr;
   assign full     = (wr_ptr == DEPTH);
   assign busy     = (state == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= LOAD;
                  wr_ptr <= '0;
                  err    <= 1'b0;
               end
            end
            LOAD: begin
               if (hs) begin
                  // illegal ops are swallowed: no write, pointer holds
                  if (legal) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= wr_ptr[ADDR_W-1:0];
                     mem_wdata <= word;
                     wr_ptr    <= wr_ptr + (ADDR_W+1)'(1);
                  end else begin
                     err <= 1'b1;
                  end
                  if (in_last) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: two instances (ADDR_W=8 and ADDR_W=2) sharing field buses.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [5:0]  in_funct = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;

   logic        start8 = 1'b0, valid8 = 1'b0, last8 = 1'b0;
   logic        ready8, we8, busy8, full8, err8;
   logic [7:0]  addr8;
   logic [31:0] wdata8;
   logic [8:0]  count8;

   logic        start2 = 1'b0, valid2 = 1'b0, last2 = 1'b0;
   logic        ready2, we2, busy2, full2, err2;
   logic [1:0]  addr2;
   logic [31:0] wdata2;
   logic [2:0]  count2;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8), .in_ready(ready8),
      .in_last(last8), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .busy(busy8),
      .full(full8), .err(err8), .count(count8));

   instr_encoder_loader #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(valid2), .in_ready(ready2),
      .in_last(last2), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .busy(busy2),
      .full(full2), .err(err2), .count(count2));

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t q8[$];
   wr_t q2[$];
   int  n_checks = 0;
   int  n_pass = 0;
   int  cyc = 0;
   int  ptr8 = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] funct, input logic [15:0] imm,
                                       input logic [25:0] tgt);
      logic [5:0] o;
      case (op)
         4'd0: return {6'd0, rs, rt, rd, 5'd0, funct};
         4'd6: return {6'b000010, tgt};
         4'd1: o = 6'h08;
         4'd2: o = 6'h31;
         4'd3: o = 6'h2B;
         4'd4: o = 6'h04;
         4'd5: o = 6'h0A;
         4'd7: o = 6'h0C;
         default: o = 6'h0D;
      endcase
      return {o, rs, rt, imm};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we8 === 1'b1) begin
         if (q8.size() == 0) check("unexpected_write8", {56'd0, addr8}, 64'hFFFF);
         else begin
            wr_t e;
            e = q8.pop_front();
            check("wr_cycle8", cyc, e.cyc);
            check("wr_addr8", addr8, e.addr);
            check("wr_data8", wdata8, e.data);
         end
      end
      if (we2 === 1'b1) begin
         if (q2.size() == 0) check("unexpected_write2", {62'd0, addr2}, 64'hFFFF);
         else begin
            wr_t e;
            e = q2.pop_front();
            check("wr_cycle2", cyc, e.cyc);
            check("wr_addr2", {6'd0, addr2}, e.addr);
            check("wr_data2", wdata2, e.data);
         end
      end
   end

   // called on a negedge; returns on the negedge after the handshake edge
   task automatic send8(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
      int waited = 0;
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
      in_funct = funct; in_imm = imm; in_target = tgt;
      last8 = last; valid8 = 1'b1;
      while (!ready8 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!ready8) begin
         check("ready_timeout", 0, 1);
         valid8 = 1'b0;
         return;
      end
      if (op <= 4'd8) begin
         q8.push_back('{cyc + 1, ptr8[7:0], enc(op, rs, rt, rd, funct, imm, tgt)});
         ptr8++;
      end
      @(posedge clk);
      @(negedge clk);
      check("count8", count8, ptr8);
      if (last) check("busy_after_last", busy8, 0);
   endtask

   task automatic do_start8();
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      ptr8 = 0;
      check("busy_after_start", busy8, 1);
      check("ready_after_start", ready8, 1);
      check("count_after_start", count8, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic hs;
      // reset state
      #3;
      check("rst_we", we8, 0);
      check("rst_addr", addr8, 0);
      check("rst_wdata", wdata8, 0);
      check("rst_busy_full_err", {busy8, full8, err8}, 0);
      check("rst_ready", ready8, 0);
      check("rst_count", count8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single ADDI
      do_start8();
      send8(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
      check("addi_word_model", enc(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0), 32'h20220005);
      valid8 = 1'b0;
      @(negedge clk);

      // back-to-back R, LW, J
      do_start8();
      send8(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'd0, 1'b0);
      send8(4'd2, 5'd0, 5'd3, 5'd7, 6'h3F, 16'd4, 26'd0, 1'b0);
      send8(4'd6, 5'd9, 5'd9, 5'd9, 6'd0, 16'd0, 26'h10, 1'b1);
      valid8 = 1'b0;
      check("err_clean", err8, 0);
      @(negedge clk);

      // illegal op in the middle, plus remaining I formats
      do_start8();
      send8(4'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0);
      send8(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
      check("err_set", err8, 1);
      send8(4'd4, 5'd6, 5'd7, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b0);
      send8(4'd5, 5'd8, 5'd9, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
      send8(4'd7, 5'd10, 5'd11, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0);
      send8(4'd8, 5'd31, 5'd30, 5'd0, 6'd0, 16'hABCD, 26'd0, 1'b1);
      valid8 = 1'b0;
      check("err_sticky", err8, 1);
      @(negedge clk);
      do_start8();
      check("err_cleared_by_start", err8, 0);
      // illegal op with last ends the session without a write
      send8(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
      valid8 = 1'b0;
      check("err_illegal_last", err8, 1);
      @(negedge clk);

      // ADDR_W=2 instance: five bundles offered, only four fit
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      k = 0;
      for (int c = 0; c < 9; c++) begin
         in_op = 4'd1; in_rs = 5'(k); in_rt = 5'(k + 1); in_imm = 16'(16'h100 + k);
         last2 = (k == 4); valid2 = 1'b1;
         hs = ready2;
         if (hs) q2.push_back('{cyc + 1, 8'(k), enc(4'd1, 5'(k), 5'(k + 1), 5'd0, 6'd0,
                                                    16'(16'h100 + k), 26'd0)});
         @(posedge clk);
         @(negedge clk);
         if (hs) begin
            k++;
            if (k == 4) check("ready_drop_at_full", ready2, 0);
         end
      end
      check("accepted_full", k, 4);
      check("full2", full2, 1);
      check("count2", count2, 4);
      check("busy2_stuck", busy2, 1);
      valid2 = 1'b0;

      // reset the cycle after a handshake drops the pending write
      do_start8();
      in_op = 4'd1; in_rs = 5'd3; in_rt = 5'd4; in_imm = 16'd9;
      last8 = 1'b0; valid8 = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      valid8 = 1'b0;
      #1;
      check("rst_mid_we", we8, 0);
      check("rst_mid_busy", busy8, 0);
      check("rst_mid_count", count8, 0);
      check("rst_mid_full2", full2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_start8();
      send8(4'd1, 5'd2, 5'd2, 5'd0, 6'd0, 16'h7777, 26'd0, 1'b1);
      valid8 = 1'b0;
      @(negedge clk);
      @(negedge clk);

      check("q8_drained", q8.size(), 0);
      check("q2_drained", q2.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Packs instruction fields into 32-bit instruction words using the opcode map the control unit decodes, and streams them into instruction memory. It sits between the testbench/boot source and the instruction-memory write port, so programs can be loaded as symbolic fields instead of raw hex. Input uses a valid/ready handshake. A single registered pipeline stage drives the memory write port, and the block tracks fill count, full and a sticky error.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load session at address 0
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- in_last  input  1  bundle is the final word of the program
- in_op  input  4  mnemonic: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 SLTI, 6 J, 7 ANDI, 8 ORI; 9–15 illegal
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_funct  input  6  R-type function field
- in_imm  input  16  I-type immediate
- in_target  input  26  J-type target
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  32  encoded instruction
- busy  output  1  state is LOAD
- full  output  1  count == DEPTH
- err  output  1  sticky: an illegal in_op was accepted
- count  output  ADDR_W+1  words written in the current session

## Operation
- States: IDLE, LOAD.
  - IDLE → LOAD on start: clears count, the write pointer and err.
  - LOAD → IDLE on acceptance of a bundle with in_last=1 (legal or illegal).
  - start is ignored while in LOAD.
- in_ready = (state==LOAD) && (wr_ptr < DEPTH). A handshake occurs when in_valid && in_ready.
- Encoding (shamt is always 0):
  - R: {6'b000000, rs, rt, rd, 5'b0, funct}
  - I: {opc, rs, rt, imm}, with opc = ADDI 001000, LW 110001, SW 101011, BEQ 000100, SLTI 001010, ANDI 001100, ORI 001101
  - J: {6'b000010, target}
  - Fields not used by a format are ignored.
- Legal accepted op:
  - The word and the current wr_ptr are registered into mem_wdata/mem_addr.
  - wr_ptr increments.
- Illegal accepted op:
  - The word is consumed with no write and no wr_ptr change.
  - err is set and stays set until the next start or reset.
- When wr_ptr reaches DEPTH, in_ready drops. The block stays in LOAD with full=1 until a bundle arrives with in_last=1, but no further bundles can be accepted. Leaving that state requires reset, so the source must assert in_last on the DEPTH-th word.
- count mirrors wr_ptr, giving range 0..DEPTH with no wrap. mem_addr is wr_ptr truncated to ADDR_W bits.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, busy=0, in_ready=0.
  - A write pending mid-load is dropped.
- Latency: handshake at edge N → mem_we=1 for exactly the cycle after edge N, with addr/data valid in that cycle.
- count increments at edge N, together with the handshake.
- Throughput: one bundle per cycle, with back-to-back writes on consecutive cycles.
- in_ready is combinational from state and wr_ptr. It does not depend on in_valid.
- full and busy are derived from registered state, so they change only on clock edges.
- A start pulse in the same cycle as a handshake cannot occur, because in_ready=0 in IDLE.
- The last write (in_last) still issues mem_we in the cycle after the block has returned to IDLE.

## Test plan
- Reset → all outputs 0; then start → busy=1, in_ready=1 next cycle.
- ADDI rs=1 rt=2 imm=5 → mem_we next cycle, mem_addr=0, mem_wdata=0x20220005; count=1.
- Back-to-back R add rs=1 rt=2 rd=3 funct=0x20, then LW rs=0 rt=3 imm=4, then J target=0x10 → consecutive writes:
  - 0x00221820 at addr 0
  - 0xC4030004 at addr 1
  - 0x08000010 at addr 2
- in_op=12 between two legal ops → err=1, no mem_we for it, addresses stay contiguous (0, 1).
- ADDR_W=2, present 5 valid bundles continuously → 4 writes (addr 0–3), full=1, in_ready=0 after the 4th handshake; the 5th bundle is never accepted.
- Assert rst_n low the cycle after a handshake → mem_we=0 immediately, no write occurs, state=IDLE; a following start resumes at addr 0.
